// File: rtl/serial_adder.sv
// serial_adder: bit-serial a+b+cin using one full-adder cell and a carry register
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d, rb_q, rb_d, rs_q, rs_d;
  logic cy_q, cy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] fa;
  assign fa = {1'b0, ra_q[0]} + {1'b0, rb_q[0]} + {1'b0, cy_q};
  always_comb begin
    state_d = state_q;
    ra_d = ra_q;
    rb_d = rb_q;
    rs_d = rs_q;
    cy_d = cy_q;
    cnt_d = cnt_q;
    if (state_q == IDLE && in_valid) begin
      ra_d = a;
      rb_d = b;
      cy_d = cin;
      rs_d = '0;
      cnt_d = '0;
      state_d = ADD;
    end else if (state_q == ADD) begin
      ra_d = ra_q >> 1;
      rb_d = rb_q >> 1;
      cy_d = fa[1];
      rs_d = (rs_q >> 1) | (WIDTH'(fa[0]) << (WIDTH - 1));
      cnt_d = cnt_q + CW'(1);
      state_d = (cnt_q == LAST) ? DONE : ADD;
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ra_q <= '0;
      rb_q <= '0;
      rs_q <= '0;
      cy_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      ra_q <= ra_d;
      rb_q <= rb_d;
      rs_q <= rs_d;
      cy_q <= cy_d;
      cnt_q <= cnt_d;
    end
  end
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy = state_q == ADD;
  // result is masked outside DONE so partial sums never leak
  assign sum = out_valid ? rs_q : '0;
  assign cout = out_valid & cy_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed WIDTH=8 vectors plus random regression at WIDTH 1, 8 and 13
module tb_serial_adder;
  logic clk, rst, rrst;
  int checks = 0, errors = 0, done_cnt = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, got, exp);
    end
  endtask

  logic d_iv, d_ir, d_ci, d_ov, d_or, d_co, d_busy;
  logic [7:0] d_a, d_b, d_sum;
  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(d_iv), .in_ready(d_ir), .a(d_a), .b(d_b), .cin(d_ci),
    .out_valid(d_ov), .out_ready(d_or), .sum(d_sum), .cout(d_co), .busy(d_busy)
  );

  typedef struct {
    logic [7:0] a, b;
    logic ci;
    logic [7:0] s;
    logic co;
  } vec_t;
  vec_t tbl[7];

  task automatic start_op(input logic [7:0] av, input logic [7:0] bv, input logic cv);
    int n = 0;
    while (!d_ir && n < 50) begin
      @(negedge clk);
      n++;
    end
    d_a = av;
    d_b = bv;
    d_ci = cv;
    d_iv = 1'b1;
    @(negedge clk);
    d_iv = 1'b0;
  endtask

  // lat counts edges from the accept edge to the edge that raises out_valid, inclusive
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!d_ov && lat < 60) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    rrst = 1'b1;
    repeat (3) @(negedge clk);
    rrst = 1'b0;
  end

  for (genvar g = 0; g < 3; g++) begin : rg
    localparam int W = (g == 0) ? 1 : (g == 1) ? 8 : 13;
    logic iv, ir, ci, ov, ordy, co, bz;
    logic [W-1:0] av, bv, sm;
    serial_adder #(.WIDTH(W)) u (
      .clk(clk), .rst(rrst), .in_valid(iv), .in_ready(ir), .a(av), .b(bv), .cin(ci),
      .out_valid(ov), .out_ready(ordy), .sum(sm), .cout(co), .busy(bz)
    );
    initial begin
      logic [W:0] exp_v;
      int acc_e, ops, e;
      bit pend, ev, eb;
      iv = 1'b0;
      ordy = 1'b0;
      av = '0;
      bv = '0;
      ci = 1'b0;
      exp_v = '0;
      acc_e = 0;
      ops = 0;
      e = 0;
      pend = 1'b0;
      repeat (5) @(negedge clk);
      for (int c = 0; c < 40000 && ops < 1000; c++) begin
        ev = pend && e >= acc_e + W;
        eb = pend && e < acc_e + W;
        chk($sformatf("w%0d_in_ready c%0d", W, c), ir, !pend);
        chk($sformatf("w%0d_out_valid c%0d", W, c), ov, ev);
        chk($sformatf("w%0d_busy c%0d", W, c), bz, eb);
        chk($sformatf("w%0d_result c%0d", W, c), {co, sm}, ev ? exp_v : '0);
        ordy = $urandom_range(0, 3) != 0;
        iv = $urandom_range(0, 7) != 0;
        av = W'($urandom);
        bv = W'($urandom);
        ci = 1'($urandom);
        if (ev && ordy) begin
          pend = 1'b0;
          ops++;
        end else if (!pend && iv) begin
          pend = 1'b1;
          acc_e = e + 1;
          exp_v = (W+1)'(av) + (W+1)'(bv) + (W+1)'(ci);
        end
        @(negedge clk);
        e++;
      end
      chk($sformatf("w%0d_ops_done", W), ops, 1000);
      done_cnt++;
    end
  end

  initial begin
    int lat, seen, t;
    tbl[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    tbl[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    tbl[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[4] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1};
    tbl[5] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};
    tbl[6] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
    rst = 1'b1;
    d_iv = 1'b0;
    d_or = 1'b1;
    d_a = '0;
    d_b = '0;
    d_ci = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_in_ready", d_ir, 1);
    chk("reset_out_valid", d_ov, 0);
    chk("reset_busy", d_busy, 0);
    chk("reset_sum", d_sum, 0);
    chk("reset_cout", d_co, 0);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      start_op(tbl[i].a, tbl[i].b, tbl[i].ci);
      chk($sformatf("vec%0d_busy", i), d_busy, 1);
      wait_valid(lat);
      chk($sformatf("vec%0d_latency", i), lat, 9);
      chk($sformatf("vec%0d_sum", i), d_sum, tbl[i].s);
      chk($sformatf("vec%0d_cout", i), d_co, tbl[i].co);
      @(negedge clk);
      chk($sformatf("vec%0d_idle_in_ready", i), d_ir, 1);
      chk($sformatf("vec%0d_idle_out_valid", i), d_ov, 0);
    end
    d_or = 1'b0;
    start_op(8'h12, 8'h34, 1'b1);
    d_a = 8'hEE;
    d_b = 8'hEE;
    d_ci = 1'b1;
    d_iv = 1'b1;
    wait_valid(lat);
    chk("bp_latency", lat, 9);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_out_valid%0d", i), d_ov, 1);
      chk($sformatf("bp_sum%0d", i), d_sum, 8'h47);
      chk($sformatf("bp_cout%0d", i), d_co, 0);
      chk($sformatf("bp_in_ready%0d", i), d_ir, 0);
      @(negedge clk);
    end
    d_iv = 1'b0;
    d_or = 1'b1;
    @(negedge clk);
    chk("bp_release_out_valid", d_ov, 0);
    chk("bp_release_in_ready", d_ir, 1);
    chk("bp_release_sum", d_sum, 0);
    start_op(8'hAA, 8'h55, 1'b0);
    repeat (3) @(negedge clk);
    chk("midrst_busy", d_busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_in_ready", d_ir, 1);
    chk("midrst_out_valid", d_ov, 0);
    chk("midrst_busy_low", d_busy, 0);
    chk("midrst_sum", d_sum, 0);
    chk("midrst_cout", d_co, 0);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      seen |= int'(d_ov);
    end
    chk("midrst_no_pulse", seen, 0);
    start_op(8'h10, 8'h20, 1'b0);
    wait_valid(lat);
    chk("post_rst_latency", lat, 9);
    chk("post_rst_sum", d_sum, 8'h30);
    chk("post_rst_cout", d_co, 0);
    t = 0;
    while (done_cnt < 3 && t < 60000) begin
      @(negedge clk);
      t++;
    end
    chk("random_finished", done_cnt, 3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
